// File: rtl/mux_n_pipe_pkg.sv
// Shared definitions for the N-way registered stream multiplexer:
// occupancy state encoding and select-width derivation.
package mux_n_pipe_pkg;

  // Encoding is {main_valid, skid_valid}; ST_ILLEGAL must never be reached.
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'b00,
    ST_ILLEGAL = 2'b01,
    ST_ONE     = 2'b10,
    ST_FULL    = 2'b11
  } pipe_state_e;

  function automatic int sel_width(input int n);
    return (n <= 32'sd2) ? 32'sd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_1.sv
// Combinational N-to-1 multiplexer over a flattened bus.
// Out-of-range selects yield zero and clear in_range.
module mux_n_1
  import mux_n_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 8,
  parameter int SEL_W = sel_width(N)
) (
  input  logic [N*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]   select,
  output logic [WIDTH-1:0]   out,
  output logic               in_range
);

  // AND-OR selection tree; no channel matches an out-of-range select
  always_comb begin
    out      = '0;
    in_range = (int'(select) < N);
    for (int k = 0; k < N; k++) begin
      out = out | (in[k*WIDTH +: WIDTH] & {WIDTH{select == SEL_W'(k)}});
    end
  end

endmodule

// File: rtl/mux_n_pipe_chk.sv
// Simulation checker for the occupancy registers of mux_n_pipe.
module mux_n_pipe_chk (
  input logic clock,
  input logic reset,
  input logic main_valid,
  input logic skid_valid
);

  // The skid register may only hold a word while main also holds one
  a_no_skid_without_main: assert property (
    @(posedge clock) disable iff (reset) !(skid_valid && !main_valid)
  );

endmodule

// File: rtl/mux_n_pipe.sv
// N-way WIDTH-bit stream mux with registered output, select echo,
// sticky out-of-range flag and a two-entry skid buffer for full throughput.
module mux_n_pipe
  import mux_n_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 8,
  parameter int SEL_W = sel_width(N)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   in_select,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_select,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sel_err
);

  logic [WIDTH-1:0] mux_data_s;
  logic             in_range_s;
  logic             accept_s;
  pipe_state_e      state_s;
  logic             main_valid_nxt_s, skid_valid_nxt_s;
  logic             load_main_s, load_skid_s, main_from_skid_s;

  logic             main_valid_r, skid_valid_r, sel_err_r;
  logic [WIDTH-1:0] main_data_r, skid_data_r;
  logic [SEL_W-1:0] main_sel_r, skid_sel_r;

  mux_n_1 #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) u_mux (
    .in       (in_data),
    .select   (in_select),
    .out      (mux_data_s),
    .in_range (in_range_s)
  );

  // in_ready depends only on state and reset, never on out_ready
  assign in_ready   = !skid_valid_r && !reset;
  assign accept_s   = in_valid && in_ready;
  assign state_s    = pipe_state_e'({main_valid_r, skid_valid_r});
  assign out_data   = main_data_r;
  assign out_select = main_sel_r;
  assign out_valid  = main_valid_r;
  assign sel_err    = sel_err_r;

  // Next occupancy and register load enables; skid drains before new input
  always_comb begin
    main_valid_nxt_s = main_valid_r;
    skid_valid_nxt_s = skid_valid_r;
    load_main_s      = 1'b0;
    load_skid_s      = 1'b0;
    main_from_skid_s = 1'b0;
    case (state_s)
      ST_EMPTY: begin
        main_valid_nxt_s = accept_s;
        load_main_s      = accept_s;
      end
      ST_ONE: begin
        if (out_ready) begin
          main_valid_nxt_s = accept_s;
          load_main_s      = accept_s;
        end else begin
          skid_valid_nxt_s = accept_s;
          load_skid_s      = accept_s;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          skid_valid_nxt_s = 1'b0;
          load_main_s      = 1'b1;
          main_from_skid_s = 1'b1;
        end else begin
          skid_valid_nxt_s = 1'b1;
        end
      end
      default: begin
        main_valid_nxt_s = 1'b0;
        skid_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Main/skid storage, occupancy and sticky select error
  always_ff @(posedge clock) begin
    if (reset) begin
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      main_data_r  <= '0;
      main_sel_r   <= '0;
      skid_data_r  <= '0;
      skid_sel_r   <= '0;
      sel_err_r    <= 1'b0;
    end else begin
      main_valid_r <= main_valid_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      if (load_main_s) begin
        main_data_r <= main_from_skid_s ? skid_data_r : mux_data_s;
        main_sel_r  <= main_from_skid_s ? skid_sel_r  : in_select;
      end
      if (load_skid_s) begin
        skid_data_r <= mux_data_s;
        skid_sel_r  <= in_select;
      end
      if (accept_s && !in_range_s) begin
        sel_err_r <= 1'b1;
      end
    end
  end

  mux_n_pipe_chk u_chk (
    .clock      (clock),
    .reset      (reset),
    .main_valid (main_valid_r),
    .skid_valid (skid_valid_r)
  );

endmodule

// File: tb/tb_mux_n_pipe.sv
// Scoreboard bench for mux_n_pipe across four WIDTH/N configurations.
module tb_mux_n_pipe;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  sel;
  } item_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  item_t q0[$];
  item_t q2[$];
  item_t q3[$];

  // dut0: WIDTH=32, N=8
  logic [255:0] in_data0 = '0;
  logic [2:0]   in_sel0 = '0, out_sel0;
  logic         in_valid0 = 1'b0, in_ready0, out_valid0, out_ready0 = 1'b0, sel_err0;
  logic [31:0]  out_data0;
  // dut1: WIDTH=32, N=6
  logic [191:0] in_data1 = '0;
  logic [2:0]   in_sel1 = '0, out_sel1;
  logic         in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b1, sel_err1;
  logic [31:0]  out_data1;
  // dut2: WIDTH=8, N=3
  logic [23:0]  in_data2 = '0;
  logic [1:0]   in_sel2 = '0, out_sel2;
  logic         in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b0, sel_err2;
  logic [7:0]   out_data2;
  // dut3: WIDTH=64, N=16
  logic [1023:0] in_data3 = '0;
  logic [3:0]    in_sel3 = '0, out_sel3;
  logic          in_valid3 = 1'b0, in_ready3, out_valid3, out_ready3 = 1'b0, sel_err3;
  logic [63:0]   out_data3;

  mux_n_pipe #(.WIDTH(32), .N(8)) dut0 (
    .clock(clock), .reset(reset), .in_data(in_data0), .in_select(in_sel0),
    .in_valid(in_valid0), .in_ready(in_ready0), .out_data(out_data0),
    .out_select(out_sel0), .out_valid(out_valid0), .out_ready(out_ready0),
    .sel_err(sel_err0));
  mux_n_pipe #(.WIDTH(32), .N(6)) dut1 (
    .clock(clock), .reset(reset), .in_data(in_data1), .in_select(in_sel1),
    .in_valid(in_valid1), .in_ready(in_ready1), .out_data(out_data1),
    .out_select(out_sel1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sel_err(sel_err1));
  mux_n_pipe #(.WIDTH(8), .N(3)) dut2 (
    .clock(clock), .reset(reset), .in_data(in_data2), .in_select(in_sel2),
    .in_valid(in_valid2), .in_ready(in_ready2), .out_data(out_data2),
    .out_select(out_sel2), .out_valid(out_valid2), .out_ready(out_ready2),
    .sel_err(sel_err2));
  mux_n_pipe #(.WIDTH(64), .N(16)) dut3 (
    .clock(clock), .reset(reset), .in_data(in_data3), .in_select(in_sel3),
    .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
    .out_select(out_sel3), .out_valid(out_valid3), .out_ready(out_ready3),
    .sel_err(sel_err3));

  // One clock: record accepts, score delivered words, then step past the edge.
  task automatic tick();
    item_t it;
    @(negedge clock);
    if (reset) begin
      q0.delete(); q2.delete(); q3.delete();
    end else begin
      if (in_valid0 && in_ready0) begin
        it.data = 64'(in_data0[int'(in_sel0)*32 +: 32]);
        it.sel  = 4'(in_sel0);
        q0.push_back(it);
      end
      if (in_valid2 && in_ready2) begin
        if (in_sel2 < 2'd3) it.data = 64'(in_data2[int'(in_sel2)*8 +: 8]);
        else                it.data = 64'd0;
        it.sel = 4'(in_sel2);
        q2.push_back(it);
      end
      if (in_valid3 && in_ready3) begin
        it.data = in_data3[int'(in_sel3)*64 +: 64];
        it.sel  = in_sel3;
        q3.push_back(it);
      end
      if (out_valid0 && out_ready0) begin
        checks++;
        if (q0.size() == 0) begin
          failures++; $display("FAIL sb0_spurious got data=%h sel=%0d required no word", out_data0, out_sel0);
        end else begin
          it = q0.pop_front();
          if ({out_data0, out_sel0} !== {it.data[31:0], it.sel[2:0]}) begin
            failures++; $display("FAIL sb0_word got %h/%0d required %h/%0d", out_data0, out_sel0, it.data[31:0], it.sel[2:0]);
          end
        end
      end
      if (out_valid2 && out_ready2) begin
        checks++;
        if (q2.size() == 0) begin
          failures++; $display("FAIL sb2_spurious got data=%h required no word", out_data2);
        end else begin
          it = q2.pop_front();
          if ({out_data2, out_sel2} !== {it.data[7:0], it.sel[1:0]}) begin
            failures++; $display("FAIL sb2_word got %h/%0d required %h/%0d", out_data2, out_sel2, it.data[7:0], it.sel[1:0]);
          end
        end
      end
      if (out_valid3 && out_ready3) begin
        checks++;
        if (q3.size() == 0) begin
          failures++; $display("FAIL sb3_spurious got data=%h required no word", out_data3);
        end else begin
          it = q3.pop_front();
          if ({out_data3, out_sel3} !== {it.data, it.sel}) begin
            failures++; $display("FAIL sb3_word got %h/%0d required %h/%0d", out_data3, out_sel3, it.data, it.sel);
          end
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    checks++;
    if ({in_ready0, out_valid0, out_data0, out_sel0, sel_err0} !== 38'd0) begin
      failures++; $display("FAIL reset_state got rdy=%b vld=%b data=%h sel=%0d err=%b required all 0",
                           in_ready0, out_valid0, out_data0, out_sel0, sel_err0);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready0 !== 1'b1) begin
      failures++; $display("FAIL reset_release_ready got %b required 1", in_ready0);
    end
  endtask

  task automatic test_single();
    in_data0[5*32 +: 32] = 32'hDEADBEEF;
    in_sel0 = 3'd5; in_valid0 = 1'b1; out_ready0 = 1'b1;
    tick();
    in_valid0 = 1'b0;
    checks++;
    if ({out_valid0, out_data0, out_sel0, sel_err0} !== {1'b1, 32'hDEADBEEF, 3'd5, 1'b0}) begin
      failures++; $display("FAIL single_word got vld=%b data=%h sel=%0d err=%b required 1/deadbeef/5/0",
                           out_valid0, out_data0, out_sel0, sel_err0);
    end
    tick();
    checks++;
    if (out_valid0 !== 1'b0 || q0.size() != 0) begin
      failures++; $display("FAIL single_drain got vld=%b pending=%0d required 0/0", out_valid0, q0.size());
    end
  endtask

  task automatic test_stream();
    for (int k = 0; k < 8; k++) in_data0[k*32 +: 32] = 32'(k) * 32'h11111111;
    out_ready0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_sel0 = 3'(i); in_valid0 = 1'b1;
      checks++;
      if (in_ready0 !== 1'b1) begin
        failures++; $display("FAIL stream_ready cycle %0d got %b required 1", i, in_ready0);
      end
      tick();
      checks++;
      if (out_valid0 !== 1'b1 || out_data0 !== 32'(i) * 32'h11111111) begin
        failures++; $display("FAIL stream_word cycle %0d got vld=%b data=%h required 1/%h",
                             i, out_valid0, out_data0, 32'(i) * 32'h11111111);
      end
    end
    in_valid0 = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic done;
    out_ready0 = 1'b0;
    in_sel0 = 3'd1; in_valid0 = 1'b1;
    tick();
    checks++;
    if (in_ready0 !== 1'b1) begin
      failures++; $display("FAIL bp_one_ready got %b required 1", in_ready0);
    end
    in_sel0 = 3'd2;
    tick();
    in_sel0 = 3'd3;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({in_ready0, out_valid0, out_data0, out_sel0} !== {1'b0, 1'b1, 32'h11111111, 3'd1}) begin
        failures++; $display("FAIL bp_stall cycle %0d got rdy=%b vld=%b data=%h sel=%0d required 0/1/11111111/1",
                             i, in_ready0, out_valid0, out_data0, out_sel0);
      end
      tick();
    end
    out_ready0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      done = in_valid0 && in_ready0;
      tick();
      if (done) in_valid0 = 1'b0;
    end
    checks++;
    if (in_valid0 !== 1'b0 || q0.size() != 0) begin
      failures++; $display("FAIL bp_drain got offer_pending=%b words_pending=%0d required 0/0", in_valid0, q0.size());
    end
  endtask

  task automatic test_reset_mid_stall();
    out_ready0 = 1'b0;
    in_sel0 = 3'd4; in_valid0 = 1'b1;
    tick();
    in_sel0 = 3'd6;
    tick();
    checks++;
    if (in_ready0 !== 1'b0) begin
      failures++; $display("FAIL rst_full_ready got %b required 0", in_ready0);
    end
    reset = 1'b1; in_valid0 = 1'b0; out_ready0 = 1'b1;
    tick();
    checks++;
    if ({out_valid0, out_data0, in_ready0} !== 34'd0) begin
      failures++; $display("FAIL rst_mid_state got vld=%b data=%h rdy=%b required 0/0/0", out_valid0, out_data0, in_ready0);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready0 !== 1'b1) begin
      failures++; $display("FAIL rst_mid_ready_after got %b required 1", in_ready0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid0 !== 1'b0) begin
        failures++; $display("FAIL rst_mid_stale cycle %0d got vld=%b required 0", i, out_valid0);
      end
    end
  endtask

  task automatic test_out_of_range();
    for (int k = 0; k < 6; k++) in_data1[k*32 +: 32] = 32'hA0000000 + 32'(k);
    out_ready1 = 1'b1;
    in_sel1 = 3'd7; in_valid1 = 1'b1;
    tick();
    checks++;
    if ({out_valid1, out_data1, out_sel1, sel_err1} !== {1'b1, 32'd0, 3'd7, 1'b1}) begin
      failures++; $display("FAIL oor_word got vld=%b data=%h sel=%0d err=%b required 1/0/7/1",
                           out_valid1, out_data1, out_sel1, sel_err1);
    end
    in_sel1 = 3'd2;
    tick();
    in_valid1 = 1'b0;
    checks++;
    if ({out_data1, sel_err1} !== {32'hA0000002, 1'b1}) begin
      failures++; $display("FAIL oor_sticky got data=%h err=%b required a0000002/1", out_data1, sel_err1);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (sel_err1 !== 1'b0) begin
      failures++; $display("FAIL oor_reset_clear got %b required 0", sel_err1);
    end
  endtask

  task automatic test_sweep();
    for (int c = 0; c < 1000; c++) begin
      in_valid2  = 1'($urandom_range(0, 1));
      in_sel2    = 2'($urandom_range(0, 3));
      in_data2   = 24'($urandom);
      out_ready2 = ($urandom_range(0, 3) != 0);
      in_valid3  = 1'($urandom_range(0, 1));
      in_sel3    = 4'($urandom_range(0, 15));
      for (int w = 0; w < 32; w++) in_data3[w*32 +: 32] = $urandom;
      out_ready3 = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid2 = 1'b0; in_valid3 = 1'b0; out_ready2 = 1'b1; out_ready3 = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (q2.size() != 0 || q3.size() != 0) begin
      failures++; $display("FAIL sweep_drain got pending2=%0d pending3=%0d required 0/0", q2.size(), q3.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_reset_mid_stall();
    test_out_of_range();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
